// File: rtl/dtree_pkg.sv
// Shared types and node-word layout helpers for the oblique decision-tree traverse engine.
package dtree_pkg;

   typedef enum logic [2:0] {StIdle, StFetch, StMac, StCmp, StDone} state_e;

   // MSB of a child field: set for a leaf, clear for an internal node index.
   localparam logic LeafFlag = 1'b1;

   function automatic int unsigned calc_ch_w(input int unsigned node_aw,
                                             input int unsigned class_w);
      return ((node_aw > class_w) ? node_aw : class_w) + 1;
   endfunction

   function automatic int unsigned calc_acc_w(input int unsigned attr_w,
                                              input int unsigned coef_w,
                                              input int unsigned n_attr);
      return attr_w + 1 + coef_w + $clog2(n_attr + 1);
   endfunction

   function automatic int unsigned calc_node_w(input int unsigned n_attr,
                                               input int unsigned coef_w,
                                               input int unsigned thr_w,
                                               input int unsigned ch_w);
      return n_attr * coef_w + thr_w + 2 * ch_w;
   endfunction

   function automatic int unsigned thr_off(input int unsigned n_attr,
                                           input int unsigned coef_w);
      return n_attr * coef_w;
   endfunction

   function automatic int unsigned left_off(input int unsigned n_attr,
                                            input int unsigned coef_w,
                                            input int unsigned thr_w);
      return thr_off(n_attr, coef_w) + thr_w;
   endfunction

   function automatic int unsigned right_off(input int unsigned n_attr,
                                             input int unsigned coef_w,
                                             input int unsigned thr_w,
                                             input int unsigned ch_w);
      return left_off(n_attr, coef_w, thr_w) + ch_w;
   endfunction

endpackage

// File: rtl/dtree_traverse_engine_if.sv
// Start/done handshake, result and node-config bus of the decision-tree traverse engine.
interface dtree_traverse_engine_if
   import dtree_pkg::*;
#(
   parameter int unsigned N_ATTR  = 3,
   parameter int unsigned ATTR_W  = 10,
   parameter int unsigned COEF_W  = 8,
   parameter int unsigned THR_W   = 16,
   parameter int unsigned NODE_AW = 5,
   parameter int unsigned CLASS_W = 8
);
   localparam int unsigned CH_W   = calc_ch_w(NODE_AW, CLASS_W);
   localparam int unsigned NODE_W = calc_node_w(N_ATTR, COEF_W, THR_W, CH_W);

   logic                       start;
   logic [N_ATTR*ATTR_W-1:0]   in_attr;
   logic                       busy;
   logic                       done;
   logic [CLASS_W-1:0]         out_class;
   logic                       err;
   logic                       cfg_we;
   logic [NODE_AW-1:0]         cfg_addr;
   logic [NODE_W-1:0]          cfg_data;
   logic [15:0]                perf_cyc;

   modport master (
      output start, in_attr, cfg_we, cfg_addr, cfg_data,
      input  busy, done, out_class, err, perf_cyc
   );

   modport slave (
      input  start, in_attr, cfg_we, cfg_addr, cfg_data,
      output busy, done, out_class, err, perf_cyc
   );

endinterface

// File: rtl/dtree_node_ram.sv
// Node memory: 1R1W synchronous RAM with registered read; read-during-write returns old data.
module dtree_node_ram #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 58
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/dtree_traverse_engine.sv
// Oblique decision-tree walker: per node a serial MAC of attributes x coefficients vs threshold.
// Define DTREE_PERF_CNT_EN to build the perf_cyc walk-length counter; otherwise perf_cyc is 0.
module dtree_traverse_engine
   import dtree_pkg::*;
#(
   parameter int unsigned N_ATTR    = 3,
   parameter int unsigned ATTR_W    = 10,
   parameter int unsigned COEF_W    = 8,
   parameter int unsigned THR_W     = 16,
   parameter int unsigned NODE_AW   = 5,
   parameter int unsigned CLASS_W   = 8,
   parameter int unsigned MAX_STEPS = 32
) (
   input logic                    clk,
   input logic                    rst,
   dtree_traverse_engine_if.slave bus
);

   localparam int unsigned CH_W      = calc_ch_w(NODE_AW, CLASS_W);
   localparam int unsigned ACC_W     = calc_acc_w(ATTR_W, COEF_W, N_ATTR);
   localparam int unsigned NODE_W    = calc_node_w(N_ATTR, COEF_W, THR_W, CH_W);
   localparam int unsigned THR_OFF   = thr_off(N_ATTR, COEF_W);
   localparam int unsigned LEFT_OFF  = left_off(N_ATTR, COEF_W, THR_W);
   localparam int unsigned RIGHT_OFF = right_off(N_ATTR, COEF_W, THR_W, CH_W);
   localparam int unsigned PROD_W    = ATTR_W + 1 + COEF_W;
   localparam int unsigned STEP_W    = $clog2(MAX_STEPS + 1);
   localparam int unsigned K_W       = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;

   state_e                     state_q, state_d;
   logic [NODE_AW-1:0]         addr_q, addr_d;
   logic [STEP_W-1:0]          step_q, step_d;
   logic [K_W-1:0]             k_q, k_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [N_ATTR*ATTR_W-1:0]   attr_q, attr_d;
   logic [CLASS_W-1:0]         class_q, class_d;
   logic                       err_q, err_d;

   logic [NODE_W-1:0]          node_word;
   logic                       busy;
   logic                       ram_we;

   logic signed [ATTR_W:0]     mac_a;
   logic signed [COEF_W-1:0]   mac_c;
   logic signed [PROD_W-1:0]   mac_p;
   logic signed [ACC_W-1:0]    thr_ext;
   logic                       go_left;
   logic [CH_W-1:0]            child;

   assign busy   = (state_q == StFetch) || (state_q == StMac) || (state_q == StCmp);
   assign ram_we = bus.cfg_we & ~busy;

   dtree_node_ram #(
      .AW (NODE_AW),
      .DW (NODE_W)
   ) u_node_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (bus.cfg_addr),
      .wdata_i (bus.cfg_data),
      .raddr_i (addr_q),
      .rdata_o (node_word)
   );

   // Attribute is zero-extended to a positive signed value before the signed multiply.
   assign mac_a   = $signed({1'b0, attr_q[k_q*ATTR_W +: ATTR_W]});
   assign mac_c   = $signed(node_word[k_q*COEF_W +: COEF_W]);
   assign mac_p   = mac_a * mac_c;
   assign thr_ext = $signed({{(ACC_W-THR_W){node_word[THR_OFF+THR_W-1]}},
                             node_word[THR_OFF +: THR_W]});
   assign go_left = (acc_q <= thr_ext);
   assign child   = go_left ? node_word[LEFT_OFF +: CH_W] : node_word[RIGHT_OFF +: CH_W];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      step_d  = step_q;
      k_d     = k_q;
      acc_d   = acc_q;
      attr_d  = attr_q;
      class_d = class_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StFetch;
               attr_d  = bus.in_attr;
               addr_d  = '0;
               step_d  = '0;
               acc_d   = '0;
            end
         end
         StFetch: begin
            k_d     = '0;
            state_d = StMac;
         end
         StMac: begin
            acc_d = acc_q + $signed({{(ACC_W-PROD_W){mac_p[PROD_W-1]}}, mac_p});
            if (k_q == K_W'(N_ATTR - 1)) begin
               state_d = StCmp;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StCmp: begin
            step_d = step_q + 1'b1;
            if (child[CH_W-1] == LeafFlag) begin
               class_d = child[CLASS_W-1:0];
               err_d   = 1'b0;
               state_d = StDone;
            end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
               class_d = '0;
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               addr_d  = child[NODE_AW-1:0];
               acc_d   = '0;
               state_d = StFetch;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         step_q  <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         attr_q  <= '0;
         class_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         attr_q  <= attr_d;
         class_q <= class_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = (state_q == StDone);
   assign bus.out_class = class_q;
   assign bus.err       = err_q;

`ifdef DTREE_PERF_CNT_EN
   logic [15:0] perf_q, perf_d;

   // Counts every cycle from the accepted start through the done cycle.
   always_comb begin
      perf_d = perf_q;
      if (state_q == StIdle) begin
         if (bus.start) begin
            perf_d = '0;
         end
      end else if (perf_q != 16'hFFFF) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign bus.perf_cyc = perf_q;
`else
   assign bus.perf_cyc = '0;
`endif

endmodule

// File: tb/tb_dtree_traverse_engine.sv
// Directed bench: two engines (MAX_STEPS 32 and 4) share stimulus; hand-computed tree results.
module tb_dtree_traverse_engine;

   logic        clk;
   logic        rst;
   logic        start;
   logic [29:0] in_attr;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [57:0] cfg_data;

   int unsigned n_vec;
   int unsigned n_miss;

   int          cyc_a, cyc_b;
   logic [7:0]  cls_a, cls_b;
   logic        err_a, err_b;

`ifdef DTREE_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   dtree_traverse_engine_if u_if_a ();
   dtree_traverse_engine_if u_if_b ();

   assign u_if_a.start    = start;
   assign u_if_a.in_attr  = in_attr;
   assign u_if_a.cfg_we   = cfg_we;
   assign u_if_a.cfg_addr = cfg_addr;
   assign u_if_a.cfg_data = cfg_data;
   assign u_if_b.start    = start;
   assign u_if_b.in_attr  = in_attr;
   assign u_if_b.cfg_we   = cfg_we;
   assign u_if_b.cfg_addr = cfg_addr;
   assign u_if_b.cfg_data = cfg_data;

   dtree_traverse_engine u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (u_if_a.slave)
   );

   dtree_traverse_engine #(
      .MAX_STEPS (4)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (u_if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] leaf(input int c);
      logic [7:0] cv;
      cv = 8'(c);
      return {1'b1, cv};
   endfunction

   function automatic logic [8:0] nd(input int i);
      logic [4:0] iv;
      iv = 5'(i);
      return {4'b0000, iv};
   endfunction

   function automatic logic [57:0] mk_node(input int c0, input int c1, input int c2,
                                           input int thr, input logic [8:0] l,
                                           input logic [8:0] r);
      logic [7:0]  k0, k1, k2;
      logic [15:0] t;
      k0 = 8'(c0);
      k1 = 8'(c1);
      k2 = 8'(c2);
      t  = 16'(thr);
      return {r, l, t, k2, k1, k0};
   endfunction

   function automatic logic [29:0] pk(input int a0, input int a1, input int a2);
      logic [9:0] v0, v1, v2;
      v0 = 10'(a0);
      v1 = 10'(a1);
      v2 = 10'(a2);
      return {v2, v1, v0};
   endfunction

   task automatic cfg_write(input logic [4:0] a, input logic [57:0] d);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the start edge; optional write to node 0 alongside
   // start (pre_we) or a start+write pulse in mid-walk cycle inj_cyc.
   task automatic walk(input logic [29:0] attr, input int budget, input int inj_cyc,
                       input logic pre_we, input logic [57:0] wdata);
      @(negedge clk);
      start    = 1'b1;
      in_attr  = attr;
      cfg_we   = pre_we;
      cfg_addr = 5'd0;
      cfg_data = wdata;
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b0;
      cyc_a = 0;
      cyc_b = 0;
      cls_a = '0;
      cls_b = '0;
      err_a = 1'b0;
      err_b = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (c == inj_cyc) begin
            start  = 1'b1;
            cfg_we = 1'b1;
         end else begin
            start  = 1'b0;
            cfg_we = 1'b0;
         end
         if (u_if_a.done && cyc_a == 0) begin
            cyc_a = c;
            cls_a = u_if_a.out_class;
            err_a = u_if_a.err;
         end
         if (u_if_b.done && cyc_b == 0) begin
            cyc_b = c;
            cls_b = u_if_b.out_class;
            err_b = u_if_b.err;
         end
         if (cyc_a != 0 && cyc_b != 0) break;
         @(negedge clk);
      end
      start  = 1'b0;
      cfg_we = 1'b0;
   endtask

   logic [57:0] n0_basic, n0_tree3, n3_tree3, n0_loop, n0_alt, n0_new;
   int          done_seen;

   initial begin
      n_vec    = 0;
      n_miss   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      in_attr  = '0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;

      n0_basic = mk_node(1, 1, 1, 10, leaf(5), leaf(7));
      n0_tree3 = mk_node(1, 1, 1, 10, leaf(5), nd(3));
      n3_tree3 = mk_node(-2, 1, 0, -4, leaf(8'h2A), leaf(8'h11));
      n0_loop  = mk_node(1, 1, 1, 10, nd(0), leaf(7));
      n0_alt   = mk_node(1, 1, 1, 10, leaf(9), leaf(9));
      n0_new   = mk_node(1, 1, 1, 10, leaf(8'h33), leaf(7));

      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(u_if_a.busy), 32'd0);
      check_eq("rst_done", 32'(u_if_a.done), 32'd0);
      check_eq("rst_class", 32'(u_if_a.out_class), 32'd0);
      check_eq("rst_err", 32'(u_if_a.err), 32'd0);
      check_eq("rst_perf", 32'(u_if_a.perf_cyc), 32'd0);
      rst = 1'b0;

      // Single-node tree: sum 9 left, 12 right, 10 left on equality.
      cfg_write(5'd0, n0_basic);
      walk(pk(2, 3, 4), 20, 0, 1'b0, '0);
      check_eq("t1_cycle", 32'(cyc_a), 32'd6);
      check_eq("t1_class", 32'(cls_a), 32'd5);
      check_eq("t1_err", 32'(err_a), 32'd0);
      @(negedge clk);
      check_eq("t1_perf", 32'(u_if_a.perf_cyc), PerfEn ? 32'd6 : 32'd0);
      walk(pk(4, 4, 4), 20, 0, 1'b0, '0);
      check_eq("t2_class", 32'(cls_a), 32'd7);
      check_eq("t2_cycle", 32'(cyc_a), 32'd6);
      walk(pk(3, 3, 4), 20, 0, 1'b0, '0);
      check_eq("t2_eq_class", 32'(cls_a), 32'd5);

      // Two visits: node0 right -> node3 with negative coef and negative threshold.
      cfg_write(5'd0, n0_tree3);
      cfg_write(5'd3, n3_tree3);
      walk(pk(4, 4, 4), 30, 0, 1'b0, '0);
      check_eq("t3_cycle", 32'(cyc_a), 32'd11);
      check_eq("t3_class", 32'(cls_a), 32'h2A);
      @(negedge clk);
      check_eq("t3_perf", 32'(u_if_a.perf_cyc), PerfEn ? 32'd11 : 32'd0);
      walk(pk(1, 6, 4), 30, 0, 1'b0, '0);
      check_eq("t3_right_class", 32'(cls_a), 32'h11);
      walk(pk(4, 3, 9), 30, 0, 1'b0, '0);
      check_eq("t3_neg_class", 32'(cls_a), 32'h2A);

      // Self-loop: aborts after MAX_STEPS visits (4 and 32).
      cfg_write(5'd0, n0_loop);
      walk(pk(1, 1, 1), 200, 0, 1'b0, '0);
      check_eq("t4_b_cycle", 32'(cyc_b), 32'd21);
      check_eq("t4_b_err", 32'(err_b), 32'd1);
      check_eq("t4_b_class", 32'(cls_b), 32'd0);
      check_eq("t4_a_cycle", 32'(cyc_a), 32'd161);
      check_eq("t4_a_err", 32'(err_a), 32'd1);
      check_eq("t4_a_class", 32'(cls_a), 32'd0);

      // Mid-walk start and cfg write are both ignored.
      cfg_write(5'd0, n0_basic);
      walk(pk(2, 3, 4), 20, 3, 1'b0, n0_alt);
      check_eq("t5_inj_cycle", 32'(cyc_a), 32'd6);
      check_eq("t5_inj_class", 32'(cls_a), 32'd5);
      walk(pk(2, 3, 4), 20, 0, 1'b0, '0);
      check_eq("t5_after_class", 32'(cls_a), 32'd5);

      // Reset in mid-walk: outputs cleared, no done pulse afterwards.
      walk(pk(2, 3, 4), 3, 0, 1'b0, '0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t5_rst_busy", 32'(u_if_a.busy), 32'd0);
      check_eq("t5_rst_done", 32'(u_if_a.done), 32'd0);
      check_eq("t5_rst_class", 32'(u_if_a.out_class), 32'd0);
      check_eq("t5_rst_err", 32'(u_if_a.err), 32'd0);
      check_eq("t5_rst_perf", 32'(u_if_a.perf_cyc), 32'd0);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (u_if_a.done) done_seen++;
      end
      check_eq("t5_rst_nodone", 32'(done_seen), 32'd0);

      // Write to node 0 in the same cycle as start: the walk sees the new word.
      walk(pk(2, 3, 4), 20, 0, 1'b1, n0_new);
      check_eq("t6_same_cyc_class", 32'(cls_a), 32'h33);
      check_eq("t6_same_cyc_cycle", 32'(cyc_a), 32'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
